// File: rtl/ddr_serialiser.sv
// Parallel-to-DDR serialiser: emits each accepted word as (d_rise, d_fall) pairs,
// one pair per clock, with a matching forwarded-clock pair and pad output-enable.
module ddr_serialiser #(
  parameter int W          = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit CLK_PHASE  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         d_rise,
  output logic         d_fall,
  output logic         sclk_rise,
  output logic         sclk_fall,
  output logic         out_en,
  output logic         busy
);

  localparam int            CW       = $clog2(W / 2 + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W / 2 - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] pairs_q, pairs_d;
  logic          d_rise_q, d_rise_d;
  logic          d_fall_q, d_fall_d;
  logic          sclk_rise_q, sclk_rise_d;
  logic          sclk_fall_q, sclk_fall_d;
  logic          out_en_q, out_en_d;
  logic          take;
  logic [W-1:0]  src;

  function automatic logic [1:0] first_pair(input logic [W-1:0] v);
    if (MSB_FIRST) return {v[W-1], v[W-2]};
    else           return {v[0], v[1]};
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v);
    if (MSB_FIRST) return v << 2;
    else           return v >> 2;
  endfunction

  assign in_ready = !rst && (pairs_q == '0);
  assign take     = in_valid && in_ready;
  // A fresh word is presented straight from in_data so its first pair needs no extra cycle.
  assign src      = take ? in_data : shreg_q;

  always_comb begin
    shreg_d              = shreg_q;
    pairs_d              = pairs_q;
    {d_rise_d, d_fall_d} = {IDLE_LEVEL, IDLE_LEVEL};
    sclk_rise_d          = 1'b0;
    sclk_fall_d          = 1'b0;
    out_en_d             = 1'b0;
    if (take || pairs_q != '0) begin
      {d_rise_d, d_fall_d} = first_pair(src);
      shreg_d              = advance(src);
      pairs_d              = take ? CNT_LOAD : pairs_q - CW'(1);
      sclk_rise_d          = !CLK_PHASE;
      sclk_fall_d          = CLK_PHASE;
      out_en_d             = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q     <= '0;
      pairs_q     <= '0;
      d_rise_q    <= IDLE_LEVEL;
      d_fall_q    <= IDLE_LEVEL;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      out_en_q    <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      pairs_q     <= pairs_d;
      d_rise_q    <= d_rise_d;
      d_fall_q    <= d_fall_d;
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      out_en_q    <= out_en_d;
    end
  end

  assign d_rise    = d_rise_q;
  assign d_fall    = d_fall_q;
  assign sclk_rise = sclk_rise_q;
  assign sclk_fall = sclk_fall_q;
  assign out_en    = out_en_q;
  assign busy      = out_en_q || (pairs_q != '0);

endmodule

// File: tb/tb_ddr_serialiser.sv
// Bench for ddr_serialiser: three instances (W=8 MSB-first, W=8 LSB-first,
// W=2 idle-high centre-aligned) checked against directed values and a pair-queue model.
module tb_ddr_serialiser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din   [3];
  logic       vld   [3];
  logic       rst_s [3];
  logic       dr [3], df [3], sr [3], sf [3], en [3], bz [3], rdy [3];

  ddr_serialiser #(.W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .CLK_PHASE(1'b0)) u0 (
    .clk(clk), .rst(rst_s[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .d_rise(dr[0]), .d_fall(df[0]), .sclk_rise(sr[0]), .sclk_fall(sf[0]),
    .out_en(en[0]), .busy(bz[0]));

  ddr_serialiser #(.W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .CLK_PHASE(1'b0)) u1 (
    .clk(clk), .rst(rst_s[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .d_rise(dr[1]), .d_fall(df[1]), .sclk_rise(sr[1]), .sclk_fall(sf[1]),
    .out_en(en[1]), .busy(bz[1]));

  ddr_serialiser #(.W(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .CLK_PHASE(1'b1)) u2 (
    .clk(clk), .rst(rst_s[2]), .in_data(din[2][1:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .d_rise(dr[2]), .d_fall(df[2]), .sclk_rise(sr[2]), .sclk_fall(sf[2]),
    .out_en(en[2]), .busy(bz[2]));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a FIFO of pairs still to be presented per instance.
  logic [1:0] mq [3][64];
  int         mhead [3];
  int         mcnt  [3];
  logic [5:0] mexp  [3];   // {d_rise, d_fall, sclk_rise, sclk_fall, out_en, busy}

  task automatic model_edge(input int u);
    int   w, tail;
    logic msb, idle, ph, rdy_m;
    logic [1:0] p;
    w     = (u == 2) ? 2 : 8;
    msb   = (u == 0);
    idle  = (u == 2);
    ph    = (u == 2);
    rdy_m = !rst_s[u] && mcnt[u] == 0;
    if (rst_s[u]) begin
      mcnt[u]  = 0;
      mhead[u] = 0;
    end else if (vld[u] && rdy_m) begin
      for (int k = 0; k < w / 2; k++) begin
        if (msb) p = {din[u][w-1-2*k], din[u][w-2-2*k]};
        else     p = {din[u][2*k], din[u][2*k+1]};
        tail = (mhead[u] + mcnt[u]) % 64;
        mq[u][tail] = p;
        mcnt[u]++;
      end
    end
    if (!rst_s[u] && mcnt[u] > 0) begin
      mexp[u]  = {mq[u][mhead[u]], (ph ? 2'b01 : 2'b10), 2'b11};
      mhead[u] = (mhead[u] + 1) % 64;
      mcnt[u]--;
    end else begin
      mexp[u] = {idle, idle, 4'b0000};
    end
  endtask

  task automatic tick();
    for (int u = 0; u < 3; u++) model_edge(u);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got, want;
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      got  = {dr[u], df[u], sr[u], sf[u], en[u], bz[u], rdy[u]};
      want = (u == 2) ? 7'b1100000 : 7'b0000000;
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_held u%0d: got %b want %b", u, got, want);
      end
    end
    for (int u = 0; u < 3; u++) rst_s[u] = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      got  = {dr[u], df[u], sr[u], sf[u], en[u], bz[u], rdy[u]};
      want = (u == 2) ? 7'b1100001 : 7'b0000001;
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_release u%0d: got %b want %b", u, got, want);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] ep [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [6:0] got, want;
    vld[0] = 1'b1;
    din[0] = 8'hB4;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_idle: got %b want 1", rdy[0]);
    end
    tick();
    vld[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got  = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
      want = {ep[k], 4'b1011, k == 3};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got %b want %b", k + 1, got, want);
      end
      tick();
    end
    got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
    n_cmp++;
    if (got !== 7'b0000001) begin
      n_fail++;
      $display("FAIL single_idle_after: got %b want 0000001", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ep [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    logic [6:0] got, want;
    vld[0] = 1'b1;
    din[0] = 8'hB4;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) din[0] = 8'h0F;
      if (c == 5) vld[0] = 1'b0;
      got  = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
      want = {ep[c-1], 4'b1011, (c == 4 || c == 8)};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %b want %b", c, got, want);
      end
      tick();
    end
    got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
    n_cmp++;
    if (got !== 7'b0000001) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got %b want 0000001", got);
    end
  endtask

  task automatic test_lsb_first();
    logic [1:0] ep [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [6:0] got, want;
    vld[1] = 1'b1;
    din[1] = 8'hB4;
    tick();
    vld[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got  = {dr[1], df[1], sr[1], sf[1], en[1], bz[1], rdy[1]};
      want = {ep[k], 4'b1011, k == 3};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lsb_cycle%0d: got %b want %b", k + 1, got, want);
      end
      tick();
    end
    got = {dr[1], df[1], sr[1], sf[1], en[1], bz[1], rdy[1]};
    n_cmp++;
    if (got !== 7'b0000001) begin
      n_fail++;
      $display("FAIL lsb_idle_after: got %b want 0000001", got);
    end
  endtask

  task automatic test_busy_hold();
    logic [1:0] ep [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [6:0] got, want;
    vld[0] = 1'b1;
    din[0] = 8'hB4;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) vld[0] = 1'b0;
      if (c == 2) begin
        vld[0] = 1'b1;
        din[0] = 8'hFF;
      end
      if (c == 5) vld[0] = 1'b0;
      got  = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
      want = {ep[c-1], 4'b1011, (c == 4 || c == 8)};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL busy_hold_cycle%0d: got %b want %b", c, got, want);
      end
      tick();
    end
    got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
    n_cmp++;
    if (got !== 7'b0000001) begin
      n_fail++;
      $display("FAIL busy_hold_idle_after: got %b want 0000001", got);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [6:0] got;
    vld[0] = 1'b1;
    din[0] = 8'hB4;
    tick();
    vld[0] = 1'b0;
    tick();
    rst_s[0] = 1'b1;
    #1;
    got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
    n_cmp++;
    if (got !== 7'b1110110) begin
      n_fail++;
      $display("FAIL rst_mid_cycle2: got %b want 1110110", got);
    end
    for (int c = 3; c <= 4; c++) begin
      tick();
      got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
      n_cmp++;
      if (got !== 7'b0000000) begin
        n_fail++;
        $display("FAIL rst_mid_cycle%0d: got %b want 0000000", c, got);
      end
    end
    rst_s[0] = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      got = {dr[0], df[0], sr[0], sf[0], en[0], bz[0], rdy[0]};
      n_cmp++;
      if (got !== 7'b0000001) begin
        n_fail++;
        $display("FAIL rst_mid_after%0d: got %b want 0000001", c, got);
      end
      tick();
    end
  endtask

  task automatic test_w2_stream();
    logic [6:0] got, want;
    logic [1:0] w;
    got = {dr[2], df[2], sr[2], sf[2], en[2], bz[2], rdy[2]};
    n_cmp++;
    if (got !== 7'b1100001) begin
      n_fail++;
      $display("FAIL w2_idle: got %b want 1100001", got);
    end
    vld[2] = 1'b1;
    din[2] = 8'h02;
    tick();
    din[2] = 8'h01;
    got = {dr[2], df[2], sr[2], sf[2], en[2], bz[2], rdy[2]};
    n_cmp++;
    if (got !== 7'b0101111) begin
      n_fail++;
      $display("FAIL w2_word10: got %b want 0101111", got);
    end
    tick();
    got = {dr[2], df[2], sr[2], sf[2], en[2], bz[2], rdy[2]};
    n_cmp++;
    if (got !== 7'b1001111) begin
      n_fail++;
      $display("FAIL w2_word01: got %b want 1001111", got);
    end
    for (int i = 0; i < 16; i++) begin
      w      = 2'($urandom_range(0, 3));
      din[2] = {6'd0, w};
      tick();
      got  = {dr[2], df[2], sr[2], sf[2], en[2], bz[2], rdy[2]};
      want = {w[0], w[1], 5'b01111};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL w2_stream%0d: got %b want %b", i, got, want);
      end
    end
    vld[2] = 1'b0;
    tick();
    got = {dr[2], df[2], sr[2], sf[2], en[2], bz[2], rdy[2]};
    n_cmp++;
    if (got !== 7'b1100001) begin
      n_fail++;
      $display("FAIL w2_idle_after: got %b want 1100001", got);
    end
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int u = 0; u < 3; u++) begin
        rst_s[u] = ($urandom_range(0, 49) == 0);
        vld[u]   = 1'($urandom_range(0, 1));
        din[u]   = 8'($urandom);
      end
      #1;
      for (int u = 0; u < 3; u++) begin
        got  = {dr[u], df[u], sr[u], sf[u], en[u], bz[u], rdy[u]};
        want = {mexp[u], !rst_s[u] && mcnt[u] == 0};
        n_cmp++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL random u%0d cyc%0d: got %b want %b", u, cyc, got, want);
        end
      end
      tick();
    end
    for (int u = 0; u < 3; u++) begin
      rst_s[u] = 1'b0;
      vld[u]   = 1'b0;
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst_s[u] = 1'b1;
      vld[u]   = 1'b0;
      din[u]   = 8'd0;
      mcnt[u]  = 0;
      mhead[u] = 0;
      mexp[u]  = 6'd0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_busy_hold();
    test_reset_mid_word();
    test_w2_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
